// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this block: FETCH_PERF_CNT_EN.
package fetch_pkg;

   localparam int ILEN = 32;

   // Defaults for the fetch_unit parameters: reset fetch address and the
   // canonical RISC-V NOP (addi x0,x0,0) driven whenever bubble=1.
   localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [ILEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

   // Fetch controller states.
   //   S_IDLE : one cycle after reset, no request outstanding
   //   S_REQ  : request to imem active, waiting for rvalid
   //   S_DROP : a redirected request is still in flight; its response is discarded
   //   S_HOLD : a response arrived under stall and is parked in the hold buffer
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   // Clear the byte-offset bits so fetch addresses stay word aligned.
   function automatic logic [ILEN-1:0] align_word(input logic [ILEN-1:0] addr);
      return addr & {{(ILEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} buffer. It parks an instruction that came back from
// imem while the pipeline was stalled, until it can be handed to IF/ID.
// clear wins over load; the controller never asserts both together.
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [ILEN-1:0] load_pc,
   input  logic [ILEN-1:0] load_inst,
   output logic            valid,
   output logic [ILEN-1:0] pc,
   output logic [ILEN-1:0] inst
);

   // Capture a parked instruction on load, drop it on clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         inst  <= load_inst;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 32-bit RISC-V core.
// Owns the fetch PC (fpc), runs a single-outstanding request to imem, applies
// stall and redirect, and drives pc/pc4/inst/bubble into the IF/ID register.
// IF/ID has no enable, so every edge that does not load a new instruction
// loads bubble=1 and inst=NOP_INST while pc/pc4 keep their old values.
//
// imem handshake: imem_req is high only in S_REQ and imem_addr (= fpc) is held
// stable while it is high. A request is closed by the edge on which
// imem_rvalid=1 is sampled; imem_rdata is only meaningful on that edge.
// A request may not be answered in the same cycle it starts.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the inst_cnt/redir_cnt
// performance counters (and the CNT_W parameter). Without it they are absent.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ILEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [ILEN-1:0] NOP_INST = DEFAULT_NOP_INST
`ifdef FETCH_PERF_CNT_EN
   ,
   parameter int              CNT_W    = 32
`endif
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [ILEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [ILEN-1:0] imem_addr,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            imem_rvalid,
   output logic [ILEN-1:0] pc,
   output logic [ILEN-1:0] pc4,
   output logic [ILEN-1:0] inst,
   output logic            bubble,
   output fetch_state_e    fsm_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [CNT_W-1:0] redir_cnt
`endif
);

   fetch_state_e    state;
   logic [ILEN-1:0] fpc;
   logic [ILEN-1:0] fpc_next;
   logic [ILEN-1:0] target;

   logic            hold_load;
   logic            hold_clear;
   logic            hold_valid;
   logic [ILEN-1:0] hold_pc;
   logic [ILEN-1:0] hold_inst;

   logic            emit_req;
   logic            emit_hold;

   // Sequential fetch address wraps naturally at 2^32.
   assign fpc_next  = fpc + 32'd4;
   assign target    = align_word(redirect_pc);

   assign imem_addr = fpc;
   assign imem_req  = (state == S_REQ);
   assign fsm_state = state;

   // Decode which edge delivers an instruction and how the hold buffer moves.
   // Redirect outranks stall, stall outranks rvalid.
   always_comb begin
      emit_req   = 1'b0;
      emit_hold  = 1'b0;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      case (state)
         S_REQ: begin
            if (!redirect && imem_rvalid) begin
               emit_req  = !stall;
               hold_load = stall;
            end
         end
         S_HOLD: begin
            hold_clear = redirect || !stall;
            emit_hold  = !redirect && !stall && hold_valid;
         end
         default: begin
            emit_req   = 1'b0;
            emit_hold  = 1'b0;
         end
      endcase
   end

   fetch_hold_buf u_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (hold_load),
      .clear     (hold_clear),
      .load_pc   (fpc),
      .load_inst (imem_rdata),
      .valid     (hold_valid),
      .pc        (hold_pc),
      .inst      (hold_inst)
   );

   // Fetch controller: state, fetch PC and the registered IF/ID outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         fpc    <= RESET_PC;
         pc     <= '0;
         pc4    <= '0;
         inst   <= NOP_INST;
         bubble <= 1'b1;
      end else begin
         // Default every edge to a bubble; only an emitting edge overrides it.
         bubble <= 1'b1;
         inst   <= NOP_INST;
         case (state)
            S_IDLE: begin
               if (redirect) begin
                  fpc <= target;
               end
               state <= S_REQ;
            end
            S_REQ: begin
               if (redirect) begin
                  // With rvalid the request is already closed and its data is
                  // thrown away; otherwise it must be drained in S_DROP.
                  fpc   <= target;
                  state <= imem_rvalid ? S_REQ : S_DROP;
               end else if (imem_rvalid) begin
                  fpc <= fpc_next;
                  if (stall) begin
                     state <= S_HOLD;
                  end else begin
                     pc     <= fpc;
                     pc4    <= fpc_next;
                     inst   <= imem_rdata;
                     bubble <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               if (redirect) begin
                  fpc <= target;
               end
               if (imem_rvalid) begin
                  state <= S_REQ;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  fpc   <= target;
                  state <= S_REQ;
               end else if (!stall) begin
                  if (emit_hold) begin
                     pc     <= hold_pc;
                     pc4    <= hold_pc + 32'd4;
                     inst   <= hold_inst;
                     bubble <= 1'b0;
                  end
                  state <= S_REQ;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Count delivered instructions and accepted redirects; both wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_cnt  <= '0;
         redir_cnt <= '0;
      end else begin
         if (emit_req || emit_hold) begin
            inst_cnt <= inst_cnt + 1'b1;
         end
         if (redirect) begin
            redir_cnt <= redir_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small imem responder driven from one
// initial block, a scoreboard queue of expected {pc, pc4, inst} tuples and a
// monitor that pops it whenever the DUT shows bubble=0.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic         clk;
   logic         rst;
   logic         stall;
   logic         redirect;
   logic [31:0]  redirect_pc;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic [31:0]  imem_rdata;
   logic         imem_rvalid;
   logic [31:0]  pc;
   logic [31:0]  pc4;
   logic [31:0]  inst;
   logic         bubble;
   fetch_state_e state_dbg;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]  inst_cnt;
   logic [31:0]  redir_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [95:0] exp_q[$];

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_rvalid (imem_rvalid),
      .pc          (pc),
      .pc4         (pc4),
      .inst        (inst),
      .bubble      (bubble),
      .fsm_state   (state_dbg)
`ifdef FETCH_PERF_CNT_EN
      ,
      .inst_cnt    (inst_cnt),
      .redir_cnt   (redir_cnt)
`endif
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      n_fail++;
      $error("FAIL watchdog observed=timeout expected=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Answer the open request after lat cycles, checking the address stays put
   // and bubbles are shown while waiting; expects the word to be emitted.
   task automatic serve(input int lat, input logic [31:0] data);
      logic [31:0] a0;
      a0 = imem_addr;
      chk("serve_req", {31'b0, imem_req}, 32'd1);
      for (int i = 1; i < lat; i++) begin
         imem_rvalid = 1'b0;
         tick();
         chk("wait_addr", imem_addr, a0);
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_bubble", {31'b0, bubble}, 32'd1);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      exp_q.push_back({a0, a0 + 32'd4, data});
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
   endtask

   // Scoreboard monitor: every emitted instruction must match the queue head.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (bubble === 1'b0) begin
            logic [95:0] e;
            n_checks++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL unexpected_emit observed pc=%h inst=%h expected no instruction", pc, inst);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("emit_pc", pc, e[95:64]);
               chk("emit_pc4", pc4, e[63:32]);
               chk("emit_inst", inst, e[31:0]);
            end
         end else begin
            chk("nop_on_bubble", inst, NOP);
         end
      end
   end

   // Directed sequence
   initial begin
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rdata  = 32'h0;
      imem_rvalid = 1'b0;
      repeat (2) @(negedge clk);

      // reset values
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc4", pc4, 32'h0);
      chk("rst_inst", inst, NOP);
      chk("rst_bubble", {31'b0, bubble}, 32'd1);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_inst_cnt", inst_cnt, 32'd0);
      chk("rst_redir_cnt", redir_cnt, 32'd0);
`endif

      // 1: reset release, one-cycle imem
      rst = 1'b1;
      tick();
      chk("t1_req", {31'b0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'h0);
      serve(1, 32'h0050_0093);
      chk("t1_next_addr", imem_addr, 32'h4);
      chk("t1_next_req", {31'b0, imem_req}, 32'd1);

      // 2: three-cycle imem latency
      serve(3, 32'h0010_0113);
      chk("t2_next_addr", imem_addr, 32'h8);

      // 3: response under stall is parked, then emitted once
      stall       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0020_8193;
      tick();
      imem_rvalid = 1'b0;
      chk("t3_bubble", {31'b0, bubble}, 32'd1);
      chk("t3_req", {31'b0, imem_req}, 32'd0);
      tick();
      chk("t3_bubble2", {31'b0, bubble}, 32'd1);
      chk("t3_req2", {31'b0, imem_req}, 32'd0);
      exp_q.push_back({32'h8, 32'hC, 32'h0020_8193});
      stall = 1'b0;
      tick();
      chk("t3_next_req", {31'b0, imem_req}, 32'd1);
      chk("t3_next_addr", imem_addr, 32'hC);
      serve(1, 32'h0031_2023);
      chk("t3_addr_10", imem_addr, 32'h10);

      // 4: redirect with request in flight; late response dropped
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      chk("t4_req", {31'b0, imem_req}, 32'd0);
      chk("t4_bubble", {31'b0, bubble}, 32'd1);
      chk("t4_addr", imem_addr, 32'h100);
      tick();
      chk("t4_req2", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0010;
      tick();
      imem_rvalid = 1'b0;
      chk("t4_req3", {31'b0, imem_req}, 32'd1);
      chk("t4_addr3", imem_addr, 32'h100);
      chk("t4_bubble3", {31'b0, bubble}, 32'd1);
      serve(2, 32'h0040_0293);
      chk("t4_next_addr", imem_addr, 32'h104);

      // 5a: redirect and rvalid on the same edge
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0104;
      tick();
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      chk("t5a_bubble", {31'b0, bubble}, 32'd1);
      chk("t5a_req", {31'b0, imem_req}, 32'd1);
      chk("t5a_addr", imem_addr, 32'h200);
      serve(1, 32'h0050_0313);

      // 5b: redirect while an instruction sits in the hold buffer
      stall       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0204;
      tick();
      imem_rvalid = 1'b0;
      chk("t5b_req", {31'b0, imem_req}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      chk("t5b_bubble", {31'b0, bubble}, 32'd1);
      chk("t5b_req2", {31'b0, imem_req}, 32'd1);
      chk("t5b_addr", imem_addr, 32'h300);
      serve(1, 32'h0060_0393);
      chk("t5b_next_addr", imem_addr, 32'h304);

      // 6: fetch at the top of the address space wraps to 0
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0304;
      tick();
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
      serve(1, 32'h0070_0413);
      chk("t6_pc", pc, 32'hFFFF_FFFC);
      chk("t6_pc4_wrap", pc4, 32'h0);
      chk("t6_addr_wrap", imem_addr, 32'h0);

      // 6: asynchronous reset while a request is waiting
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      chk("t6_drop_addr", imem_addr, 32'h40);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0000;
      tick();
      imem_rvalid = 1'b0;
      chk("t6_req40", {31'b0, imem_req}, 32'd1);
      tick();
      chk("t6_wait_bubble", {31'b0, bubble}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_req", {31'b0, imem_req}, 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_pc", pc, 32'h0);
      chk("arst_pc4", pc4, 32'h0);
      chk("arst_bubble", {31'b0, bubble}, 32'd1);
      chk("arst_inst", inst, NOP);
      @(negedge clk);
      // stale response during reset and after release must be ignored
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0040;
      @(negedge clk);
      rst         = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0080;
      tick();
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      chk("idle_redir_req", {31'b0, imem_req}, 32'd1);
      chk("idle_redir_addr", imem_addr, 32'h80);
      chk("idle_redir_bubble", {31'b0, bubble}, 32'd1);
      serve(1, 32'h0080_0493);
      chk("final_addr", imem_addr, 32'h84);
`ifdef FETCH_PERF_CNT_EN
      chk("inst_cnt", inst_cnt, 32'd1);
      chk("redir_cnt", redir_cnt, 32'd1);
`endif

      repeat (2) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
